// File: rtl/gt_cache_pkg.sv
// Shared FSM state type and address-split helpers for the set-associative byte cache.
package gt_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL,
    ST_WAIT
  } state_e;

  function automatic int off_bits(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int line_bytes, input int sets);
    return addr_w - idx_bits(sets) - off_bits(line_bytes);
  endfunction

endpackage

// File: rtl/gt_cache_way.sv
// One cache way: per-set valid/dirty/tag/line storage, combinational lookup,
// single synchronous write port used both for line install and byte merge.
module gt_cache_way #(
  parameter int SETS   = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              hit_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              wr_en_i,
  input  logic              wr_dirty_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = line_q[idx_i];
  assign hit_o   = valid_o && (tag_o == tag_i);

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= wr_dirty_i;
    end
  end

  // Payload is not reset: contents are meaningless until valid is set.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      tag_q[idx_i]  <= tag_i;
      line_q[idx_i] <= wr_line_i;
    end
  end

endmodule

// File: rtl/gt_set_assoc_cache.sv
// Set-associative write-back/write-allocate byte cache with round-robin victims,
// ready/valid line-wide memory port and saturating hit/miss counters.
module gt_set_assoc_cache
  import gt_cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int CNT_W      = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic                    req_we,
  input  logic [7:0]              req_wdata,
  output logic                    resp_valid,
  output logic [7:0]              resp_data,
  output logic                    hit,
  output logic                    miss,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [8*LINE_BYTES-1:0] toMemData,
  input  logic                    mem_resp_valid,
  input  logic [8*LINE_BYTES-1:0] memData,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int OFF_W  = off_bits(LINE_BYTES);
  localparam int IDX_W  = idx_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_W, LINE_BYTES, SETS);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [7:0]          wdata_q;
  logic [PTR_W-1:0]    ptr_q [SETS];
  logic                resp_valid_q, hit_q, miss_q;
  logic [7:0]          resp_data_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [OFF_W-1:0]    off;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [PTR_W-1:0]    victim;

  logic [WAYS-1:0]              w_hit, w_valid, w_dirty, way_we;
  logic [WAYS-1:0][TAG_W-1:0]   w_tag;
  logic [WAYS-1:0][LINE_W-1:0]  w_line;
  logic                         any_hit;
  logic [PTR_W-1:0]             hit_way;
  logic [LINE_W-1:0]            hit_line, wr_line;
  logic                         wr_dirty;
  logic                         fill_done;

  assign off       = addr_q[OFF_W-1:0];
  assign idx       = addr_q[OFF_W +: IDX_W];
  assign tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign victim    = ptr_q[idx];
  assign fill_done = (state_q == ST_WAIT) && mem_resp_valid;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    gt_cache_way #(
      .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)
    ) u_way (
      .CLK        (CLK),
      .RST        (RST),
      .idx_i      (idx),
      .tag_i      (tag),
      .hit_o      (w_hit[w]),
      .valid_o    (w_valid[w]),
      .dirty_o    (w_dirty[w]),
      .tag_o      (w_tag[w]),
      .line_o     (w_line[w]),
      .wr_en_i    (way_we[w]),
      .wr_dirty_i (wr_dirty),
      .wr_line_i  (wr_line)
    );
  end

  always_comb begin
    any_hit  = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit[w]) begin
        any_hit  = 1'b1;
        hit_way  = PTR_W'(w);
        hit_line = w_line[w];
      end
    end
  end

  // One write port serves both a write hit (merge into hit way) and a fill (install into victim).
  always_comb begin
    way_we   = '0;
    wr_dirty = 1'b1;
    wr_line  = hit_line;
    if (state_q == ST_LOOKUP && any_hit && we_q) begin
      way_we[hit_way] = 1'b1;
    end else if (fill_done) begin
      way_we[victim] = 1'b1;
      wr_dirty       = we_q;
      wr_line        = memData;
    end
    if (we_q) wr_line[{off, 3'b000} +: 8] = wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (any_hit)                                state_d = ST_IDLE;
        else if (w_valid[victim] && w_dirty[victim]) state_d = ST_WB;
        else                                        state_d = ST_FILL;
      end
      ST_WB:     if (mem_req_ready) state_d = ST_FILL;
      ST_FILL:   if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT:   if (mem_resp_valid) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == ST_IDLE);
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    toMemData     = '0;
    case (state_q)
      ST_WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {w_tag[victim], idx, {OFF_W{1'b0}}};
        toMemData     = w_line[victim];
      end
      ST_FILL: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag, idx, {OFF_W{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      if (state_q == ST_IDLE && req_valid) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_LOOKUP && any_hit) begin
        resp_valid_q <= 1'b1;
        hit_q        <= 1'b1;
        resp_data_q  <= we_q ? wdata_q : hit_line[{off, 3'b000} +: 8];
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end
      if (fill_done) begin
        resp_valid_q <= 1'b1;
        miss_q       <= 1'b1;
        resp_data_q  <= we_q ? wdata_q : memData[{off, 3'b000} +: 8];
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        ptr_q[idx]   <= (WAYS == 1) ? '0 : victim + 1'b1;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_gt_set_assoc_cache.sv
// Directed plus randomized bench for gt_set_assoc_cache against a behavioural cache/memory model.
module tb_gt_set_assoc_cache;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic         CLK = 1'b0;
  logic         RST;
  logic         req_valid, req_ready, req_we;
  logic [31:0]  req_addr;
  logic [7:0]   req_wdata;
  logic         resp_valid, hit, miss;
  logic [7:0]   resp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [255:0] toMemData, memData;
  logic         mem_resp_valid;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  always #5 CLK = ~CLK;

  gt_set_assoc_cache #(
    .ADDR_W(32), .LINE_BYTES(32), .SETS(16), .WAYS(2), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .hit(hit), .miss(miss),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .toMemData(toMemData),
    .mem_resp_valid(mem_resp_valid), .memData(memData),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: cache contents per set/way plus a sparse backing memory.
  logic         m_valid [16][2];
  logic         m_dirty [16][2];
  logic [22:0]  m_tag   [16][2];
  logic [255:0] m_line  [16][2];
  int           m_ptr   [16];
  int           hc, mc;
  logic [255:0] mem_m [logic [31:0]];

  logic [31:0]  last_fill_addr, last_wb_addr;
  logic [255:0] last_wb_data;
  logic [7:0]   last_rdata;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_line[s][w]  = '0;
      end
    end
    hc = 0;
    mc = 0;
  endtask

  task automatic get_line(input logic [31:0] la, output logic [255:0] l);
    if (!mem_m.exists(la)) begin
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      mem_m[la] = l;
    end
    l = mem_m[la];
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  // Issue one request, act as memory (with 'stall' not-ready cycles), check everything seen.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [7:0] d, input int stall);
    int s, off, v, cyc, k, ph;
    logic [22:0]  t;
    logic [31:0]  la, wba;
    logic [255:0] fl, wbl, ln;
    logic [7:0]   ed;
    bit           mh, exp_wb, done;
    s   = int'(a[8:5]);
    off = int'(a[4:0]);
    t   = a[31:9];
    la  = {a[31:5], 5'b0};
    mh  = 1'b0;
    v   = 0;
    exp_wb = 1'b0;
    wba = '0;
    wbl = '0;
    fl  = '0;
    for (int i = 0; i < 2; i++)
      if (m_valid[s][i] && m_tag[s][i] == t) begin mh = 1'b1; v = i; end
    if (mh) begin
      hc++;
      if (w) m_dirty[s][v] = 1'b1;
    end else begin
      mc++;
      v      = m_ptr[s];
      exp_wb = m_valid[s][v] && m_dirty[s][v];
      wba    = {m_tag[s][v], 4'(s), 5'b0};
      wbl    = m_line[s][v];
      if (exp_wb) mem_m[wba] = wbl;
      get_line(la, fl);
      m_line[s][v]  = fl;
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_dirty[s][v] = w;
      m_ptr[s]      = (m_ptr[s] + 1) % 2;
    end
    ln = m_line[s][v];
    if (w) ln[off*8 +: 8] = d;
    m_line[s][v] = ln;
    ed = ln[off*8 +: 8];

    @(negedge CLK);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = w;
    req_wdata = d;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_we    = $urandom_range(0, 1);
    req_wdata = 8'($urandom);

    ph   = mh ? 0 : (exp_wb ? 1 : 2);
    cyc  = 0;
    k    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge CLK);
      cyc++;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (cyc > 300) begin
        chk("timeout_resp_valid", resp_valid, 1'b1);
        done = 1'b1;
      end else if (resp_valid) begin
        chk("hit", hit, mh);
        chk("miss", miss, !mh);
        chk("resp_data", resp_data, ed);
        if (mh) chk("hit_latency", cyc, 2);
        else    chk("miss_resp_after_fill", ph, 4);
        chk("hit_cnt", hit_cnt, sat(hc));
        chk("miss_cnt", miss_cnt, sat(mc));
        last_rdata = resp_data;
        done = 1'b1;
      end else begin
        case (ph)
          1: if (mem_req_valid) begin
            k++;
            chk("wb_we", mem_req_we, 1'b1);
            chk("wb_addr", mem_req_addr, wba);
            chk("wb_data", toMemData, wbl);
            last_wb_addr = mem_req_addr;
            last_wb_data = toMemData;
            if (k > stall) begin mem_req_ready = 1'b1; ph = 2; k = 0; end
          end
          2: if (mem_req_valid) begin
            k++;
            chk("fill_we", mem_req_we, 1'b0);
            chk("fill_addr", mem_req_addr, la);
            last_fill_addr = mem_req_addr;
            if (k > stall) begin mem_req_ready = 1'b1; ph = 3; k = 0; end
          end
          3: begin
            k++;
            chk("wait_no_mem_req", mem_req_valid, 1'b0);
            if (k > stall) begin mem_resp_valid = 1'b1; memData = fl; ph = 4; end
          end
          4: begin
            chk("miss_resp_valid", resp_valid, 1'b1);
            done = 1'b1;
          end
          default: ;
        endcase
      end
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge CLK);
    chk("resp_pulse_one_cycle", resp_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l;
    int           k;
    RST            = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_we         = 1'b0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    memData        = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_hit_miss", {hit, miss}, 2'b00);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_req_we", mem_req_we, 1'b0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_toMemData", toMemData, 256'h0);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);

    // Read miss then hit
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    l[39:32] = 8'hA5;
    mem_m[32'h1000] = l;
    do_req(32'h1004, 1'b0, 8'h00, 0);
    chk("t1_fill_addr", last_fill_addr, 32'h1000);
    chk("t1_miss_data", last_rdata, 8'hA5);
    do_req(32'h1004, 1'b0, 8'h00, 0);
    chk("t1_hit_data", last_rdata, 8'hA5);
    chk("t1_hit_cnt", hit_cnt, 1);
    chk("t1_miss_cnt", miss_cnt, 1);

    // Dirty eviction with memory stalls on both WB and FILL
    do_req(32'h1004, 1'b1, 8'h3C, 0);
    do_req(32'h2000, 1'b0, 8'h00, 0);
    do_req(32'h3000, 1'b0, 8'h00, 5);
    chk("t2_wb_addr", last_wb_addr, 32'h1000);
    chk("t2_wb_byte4", last_wb_data[39:32], 8'h3C);
    chk("t2_fill_addr", last_fill_addr, 32'h3000);

    // Write miss allocate
    do_req(32'h4008, 1'b1, 8'h77, 2);
    do_req(32'h4008, 1'b0, 8'h00, 0);
    chk("t3_read_back", last_rdata, 8'h77);

    // Reset in WAIT abandons the miss
    @(negedge CLK);
    req_valid = 1'b1;
    req_addr  = 32'h5000;
    req_we    = 1'b0;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    k = 0;
    while (!mem_req_valid && k < 20) begin @(negedge CLK); k++; end
    chk("t4_fill_issued", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge CLK);
    mem_req_ready = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    chk("t4_mem_req_valid", mem_req_valid, 1'b0);
    chk("t4_resp_valid", resp_valid, 1'b0);
    chk("t4_req_ready", req_ready, 1'b1);
    mem_resp_valid = 1'b1;
    memData = '1;
    @(negedge CLK);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_late_resp_ignored", resp_valid, 1'b0);
      chk("t4_no_mem_req", mem_req_valid, 1'b0);
      @(negedge CLK);
    end
    do_req(32'h5000, 1'b0, 8'h00, 0);
    chk("t4_miss_again", miss_cnt, 1);

    // Randomized traffic on a few sets and tags
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 5)) << 9) | (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 31));
      do_req(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3));
    end

    // Counter saturation
    do_reset();
    for (int n = 0; n < 20; n++) do_req(32'h10000 + 32'(n) * 32'h200, 1'b0, 8'h00, 0);
    chk("sat_miss_cnt", miss_cnt, 4'hF);
    chk("sat_hit_cnt", hit_cnt, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gt_set_assoc_cache.md
# gt_set_assoc_cache

Parametrised set-associative, write-back, write-allocate byte cache. It is the successor to the single-way direct-mapped cache in the GT memory model. It sits between the trace-driven request source and the line-wide memory model, and adds associativity, byte writes, dirty-line writeback, ready/valid memory handshakes and hit/miss statistics counters.

## Interface
- ADDR_W, 32, byte address width
- LINE_BYTES, 32, bytes per line (power of two; 32 gives 256-bit lines)
- SETS, 16, number of sets (power of two)
- WAYS, 2, associativity (power of two, ≥1)
- CNT_W, 32, statistics counter width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  cache can accept; high only in IDLE
- req_addr  in  ADDR_W  byte address
- req_we  in  1  1 = byte write, 0 = byte read
- req_wdata  in  8  write byte
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_data  out  8  read byte, or the written byte for writes
- hit  out  1  valid with resp_valid
- miss  out  1  valid with resp_valid; equals ~hit
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = writeback, 0 = line fill
- mem_req_addr  out  ADDR_W  line-aligned address (offset bits zero)
- toMemData  out  8*LINE_BYTES  writeback line
- mem_resp_valid  in  1  fill data present (one cycle)
- memData  in  8*LINE_BYTES  fill line
- hit_cnt, miss_cnt  out  CNT_W  saturating statistics counters

## Operation
- Address split:
  - OFF_W = log2(LINE_BYTES), IDX_W = log2(SETS), TAG_W = ADDR_W − IDX_W − OFF_W.
  - offset = addr[OFF_W-1:0], index = next IDX_W bits, tag = top bits.
  - Byte lane = line[8*offset +: 8].
- Per way per set: valid, dirty, tag, line. Per set: round-robin victim pointer, log2(WAYS) bits. The pointer advances by one, wrapping, on every fill into that set.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch addr/we/wdata → LOOKUP.
  - LOOKUP: compare the tag against every valid way.
    - Hit: read, or merge the byte and set dirty; register the response; → IDLE.
    - Miss, victim valid & dirty → WB.
    - Miss, otherwise → FILL.
  - WB: mem_req_valid=1, we=1, addr={victim tag, index, 0}, toMemData=victim line. Held stable until mem_req_ready=1 → FILL.
  - FILL: mem_req_valid=1, we=0, addr={req tag, index, 0}. Held until mem_req_ready=1 → WAIT.
  - WAIT: on mem_resp_valid, install memData in the victim way: valid=1, tag=req tag, dirty=req_we, write byte merged. Register the response with miss=1. Advance the pointer. → IDLE.
- Invalid ways are not preferred: the victim is always the pointer way.
- hit_cnt increments on every hit response and miss_cnt on every miss response. Both saturate at 2^CNT_W − 1.
- mem_resp_valid outside WAIT is ignored.

## Timing
- Hit: accepted on edge 0, resp_valid high for cycle 2 only. req_ready is high again in cycle 2, so back-to-back hits give one response per 2 cycles.
- Clean miss: resp_valid goes high the cycle after the edge that samples mem_resp_valid.
- Dirty miss: the writeback handshake completes before the fill request is issued. There is never more than one outstanding memory request.
- mem_req_* must be stable while mem_req_valid=1 and mem_req_ready=0.
- Reset values:
  - Outputs: all 0 except req_ready=1 (state IDLE).
  - Storage: all valid/dirty bits 0, pointers 0, counters 0.
- Reset mid-miss abandons the transaction:
  - mem_req_valid=0 the cycle after RST.
  - No response is issued.
  - A late mem_resp_valid is ignored.
- RST takes priority over all other inputs.

## Structure
- Package gt_cache_pkg:
  - State enum (IDLE, LOOKUP, WB, FILL, WAIT).
  - clog2-based helper functions for OFF_W/IDX_W/TAG_W.
- Sub-module gt_cache_way:
  - One way's valid/dirty/tag/line arrays.
  - Combinational read port (tag match, line out) and a single synchronous write port (install or byte merge).
  - Instantiated WAYS times with a generate loop.
- Victim pointers, FSM and counters live in the top module.

## Test plan
Default parameters; addresses 0x1000, 0x2000 and 0x3000 all map to index 0.
- **Read miss then hit:** after reset, read 0x1004.
  - Expect mem read request at addr 0x1000.
  - Return memData with byte 4 = 0xA5 → resp_data=0xA5, miss=1.
  - Re-read 0x1004 → hit=1, 0xA5, 2-cycle latency.
  - hit_cnt=1, miss_cnt=1.
- **Dirty eviction:**
  - Write 0x1004←0x3C: hit, dirty.
  - Read 0x2000: miss, fills way 1.
  - Read 0x3000: writeback request we=1, addr 0x1000, byte 4 of toMemData = 0x3C, then fill request at 0x3000.
- **Memory stall:** hold mem_req_ready=0 for 5 cycles during WB and during FILL. mem_req_valid, addr and toMemData must remain stable.
- **Write miss allocate:**
  - Write 0x4008←0x77 on a clean miss → fill, then the line is dirty.
  - Read 0x4008 → hit, 0x77.
- **Reset mid-miss:**
  - Assert RST in WAIT → mem_req_valid and resp_valid stay 0.
  - A following mem_resp_valid is ignored.
  - Re-reading the same address misses again.
- **Saturation:** with CNT_W=4, 20 misses → miss_cnt=15.
